// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU command sequencer and its MUL stepper.
package alu_seq_pkg;

   localparam int unsigned WIDTH_DEF    = 16;
   localparam int unsigned MUL_CNTW_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/alu_mul_stepper.sv
// Accumulator / multiplier-shift register for the unsigned shift-and-add multiply.
// Each step folds the external ALU sum back in and shifts {acc,q} right by one.
module alu_mul_stepper #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNTW  = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] alu_o,
   input  logic             alu_cout,
   output logic [WIDTH-1:0] acc_d,
   output logic [WIDTH-1:0] q_d,
   output logic             last
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] q_q;
   logic [CNTW-1:0]  cnt_q;
   logic [CNTW-1:0]  cnt_d;

   // Next-value logic for accumulator, multiplier shift register and step count.
   always_comb begin
      acc_d = acc_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      if (start) begin
         acc_d = {WIDTH{1'b0}};
         q_d   = b_in;
         cnt_d = {CNTW{1'b0}};
      end else if (step) begin
         acc_d = {alu_cout, alu_o[WIDTH-1:1]};
         q_d   = {alu_o[0], q_q[WIDTH-1:1]};
         cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
         acc_d = acc_q;
      end
   end

   // Stepper state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= {WIDTH{1'b0}};
         q_q   <= {WIDTH{1'b0}};
         cnt_q <= {CNTW{1'b0}};
      end else begin
         acc_q <= acc_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign last = (cnt_q == CNTW'(WIDTH - 1));

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for the external 16-bit ALU: one command in flight, registered
// ALU drive, 16-step MUL using the ALU adder, registered 32-bit response.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned MUL_CNTW = MUL_CNTW_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_op,
   input  logic [WIDTH-1:0]   cmd_a,
   input  logic [WIDTH-1:0]   cmd_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH-1:0] rsp_data,
   output logic               rsp_err,
   output logic [1:0]         alu_op,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic [WIDTH-1:0]   alu_o,
   input  logic               alu_cout
);

   if (WIDTH != 16) begin : g_width_chk
      $error("alu_op_sequencer: WIDTH must be 16 to match the ALU");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic               rsp_err_q, rsp_err_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               cmd_ready_q, cmd_ready_d;
   logic [1:0]         alu_op_q, alu_op_d;
   logic [WIDTH-1:0]   alu_a_q, alu_a_d;
   logic [WIDTH-1:0]   alu_b_q, alu_b_d;
   logic               mul_start_s;
   logic               mul_step_s;
   logic               mul_last_s;
   logic [WIDTH-1:0]   acc_d_s;
   logic [WIDTH-1:0]   q_d_s;

   alu_mul_stepper #(
      .WIDTH (WIDTH),
      .CNTW  (MUL_CNTW)
   ) u_mul_stepper (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (mul_start_s),
      .step     (mul_step_s),
      .b_in     (cmd_b),
      .alu_o    (alu_o),
      .alu_cout (alu_cout),
      .acc_d    (acc_d_s),
      .q_d      (q_d_s),
      .last     (mul_last_s)
   );

   // Next-state and next-output logic; ALU drive is precomputed for the following cycle.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      alu_op_d    = ALU_ADD;
      alu_a_d     = {WIDTH{1'b0}};
      alu_b_d     = {WIDTH{1'b0}};
      mul_start_s = 1'b0;
      mul_step_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               a_d        = cmd_a;
               rsp_data_d = {(2*WIDTH){1'b0}};
               rsp_err_d  = 1'b0;
               case (cmd_op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                     state_d  = ST_EXEC;
                     alu_op_d = cmd_op[1:0];
                     alu_a_d  = cmd_a;
                     alu_b_d  = cmd_b;
                  end
                  OP_MUL: begin
                     state_d     = ST_MUL;
                     mul_start_s = 1'b1;
                     alu_b_d     = cmd_b[0] ? cmd_a : {WIDTH{1'b0}};
                  end
                  default: begin
                     state_d   = ST_RESP;
                     rsp_err_d = 1'b1;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_data_d = {{(WIDTH-1){1'b0}}, alu_cout, alu_o};
            state_d    = ST_RESP;
         end
         ST_MUL: begin
            mul_step_s = 1'b1;
            if (mul_last_s) begin
               rsp_data_d = {acc_d_s, q_d_s};
               state_d    = ST_RESP;
            end else begin
               alu_a_d = acc_d_s;
               alu_b_d = q_d_s[0] ? a_q : {WIDTH{1'b0}};
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      cmd_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         a_q         <= {WIDTH{1'b0}};
         rsp_data_q  <= {(2*WIDTH){1'b0}};
         rsp_err_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b1;
         alu_op_q    <= ALU_ADD;
         alu_a_q     <= {WIDTH{1'b0}};
         alu_b_q     <= {WIDTH{1'b0}};
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 16-bit ripple ALU wired to its alu_* ports.
module tb_alu_op_sequencer;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [1:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_o;
   logic        alu_cout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] data;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   alu_op_sequencer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_o     (alu_o),
      .alu_cout  (alu_cout)
   );

   // Reference ALU: op[0] is carry-in, SUB adds the inverted operand.
   always_comb begin
      logic [16:0] sum;
      sum = 17'd0;
      case (alu_op)
         2'b00:   sum = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01:   sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
         2'b10:   sum = {1'b0, alu_a & alu_b};
         default: sum = {1'b0, alu_a | alu_b};
      endcase
      alu_o    = sum[15:0];
      alu_cout = sum[16];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_a     = v.a;
      cmd_b     = v.b;
      chk($sformatf("v%0d_cmd_ready_idle", idx), {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = 16'h0;
      cmd_b     = 16'h0;
      if (v.op < 3'd4) begin
         chk($sformatf("v%0d_alu_op", idx), {30'd0, alu_op}, {30'd0, v.op[1:0]});
         chk($sformatf("v%0d_alu_a", idx), {16'd0, alu_a}, {16'd0, v.a});
      end
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk($sformatf("v%0d_latency", idx), lat, v.lat);
      chk($sformatf("v%0d_rsp_data", idx), rsp_data, v.data);
      chk($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.err});
      chk($sformatf("v%0d_cmd_ready_busy", idx), {31'd0, cmd_ready}, 32'd0);
      chk($sformatf("v%0d_alu_idle", idx), {14'd0, alu_op, alu_a}, 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_rsp_valid_drop", idx), {31'd0, rsp_valid}, 32'd0);
   endtask

   initial begin
      int hold_bad;
      int spurious;
      vec_t bp;
      vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 2};
      vecs[1]  = '{3'd1, 16'h0005, 16'h0003, 32'h0001_0002, 1'b0, 2};
      vecs[2]  = '{3'd2, 16'hF0F0, 16'h0FF0, 32'h0000_00F0, 1'b0, 2};
      vecs[3]  = '{3'd3, 16'hF000, 16'h000F, 32'h0000_F00F, 1'b0, 2};
      vecs[4]  = '{3'd4, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 17};
      vecs[5]  = '{3'd4, 16'h1234, 16'h0000, 32'h0000_0000, 1'b0, 17};
      vecs[6]  = '{3'd4, 16'h0003, 16'h0005, 32'h0000_000F, 1'b0, 17};
      vecs[7]  = '{3'd6, 16'h1234, 16'h5678, 32'h0000_0000, 1'b1, 1};
      vecs[8]  = '{3'd0, 16'h0001, 16'h0001, 32'h0000_0002, 1'b0, 2};
      vecs[9]  = '{3'd1, 16'h0003, 16'h0005, 32'h0000_FFFE, 1'b0, 2};
      vecs[10] = '{3'd4, 16'h00FF, 16'h0100, 32'h0000_FF00, 1'b0, 17};
      vecs[11] = '{3'd5, 16'hAAAA, 16'h5555, 32'h0000_0000, 1'b1, 1};
      vecs[12] = '{3'd7, 16'hFFFF, 16'hFFFF, 32'h0000_0000, 1'b1, 1};
      vecs[13] = '{3'd0, 16'h8000, 16'h8000, 32'h0001_0000, 1'b0, 2};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_a     = 16'h0;
      cmd_b     = 16'h0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_alu", {14'd0, alu_op, alu_a}, 32'd0);
      chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

      for (int i = 0; i < 14; i++) begin
         run_vec(vecs[i], i);
      end

      // Back-pressure: result and busy state held while a competing command is offered.
      bp = '{3'd0, 16'h1111, 16'h2222, 32'h0000_3333, 1'b0, 2};
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = bp.op;
      cmd_a     = bp.a;
      cmd_b     = bp.b;
      @(posedge clk);
      #1;
      cmd_op = 3'd4;
      cmd_a  = 16'hDEAD;
      cmd_b  = 16'hBEEF;
      @(posedge clk);
      #1;
      hold_bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (!rsp_valid || rsp_data !== bp.data || cmd_ready || rsp_err) hold_bad++;
         @(posedge clk);
         #1;
      end
      chk("bp_hold_cycles_bad", hold_bad, 0);
      chk("bp_rsp_data", rsp_data, bp.data);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      spurious = 0;
      for (int c = 0; c < 20; c++) begin
         if (rsp_valid || !cmd_ready) spurious++;
         @(posedge clk);
         #1;
      end
      chk("bp_no_extra_cmd", spurious, 0);

      // Reset during a multiply: in-flight command dropped, no response.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      cmd_a     = 16'hFFFF;
      cmd_b     = 16'hFFFF;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("mr_busy_before", {31'd0, cmd_ready}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mr_alu", {14'd0, alu_op, alu_a}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      spurious = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) spurious++;
      end
      chk("mr_no_rsp", spurious, 0);
      run_vec('{3'd0, 16'h0002, 16'h0002, 32'h0000_0004, 1'b0, 2}, 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
